// File: rtl/heichips25_spi_bridge_pkg.sv
// Shared types and constants for the heichips25 SPI-to-tile bring-up bridge.
// Optional loopback (HEICHIPS25_SPI_BRIDGE_LOOPBACK_EN) is handled in the top.
package heichips25_spi_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_UI     = 2'd0;
  localparam logic [1:0] ADDR_UIO    = 2'd1;
  localparam logic [1:0] ADDR_UO     = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int STAT_RST_BIT   = 0;
  localparam int STAT_ABORT_BIT = 1;
  localparam int STAT_LOOP_BIT  = 2;

  localparam int FRAME_BITS = 16;
  localparam int BYTE_BITS  = 8;

  // Pad-level view of the bidirectional pins: driven bits show the tile, others show our input.
  function automatic logic [7:0] uio_merge(input logic [7:0] uio_out,
                                           input logic [7:0] uio_oe,
                                           input logic [7:0] uio_in);
    return (uio_out & uio_oe) | (uio_in & ~uio_oe);
  endfunction

endpackage

// File: rtl/heichips25_sync_edge.sv
// Multi-stage synchroniser with registered rise/fall detect; an edge pulse
// appears SYNC_STAGES+1 clks after the pin changes.
module heichips25_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {SYNC_STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
      rise  <= chain[SYNC_STAGES-1] & ~prev;
      fall  <= ~chain[SYNC_STAGES-1] & prev;
    end
  end

  assign sync = chain[SYNC_STAGES-1];

endmodule

// File: rtl/heichips25_spi_io_bridge.sv
// SPI-slave (mode 0) to heichips25 tile pin bridge, fully oversampled in clk.
// Optional feature macro: HEICHIPS25_SPI_BRIDGE_LOOPBACK_EN (STATUS bit2 loopback).
module heichips25_spi_io_bridge
  import heichips25_spi_bridge_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] UI_RESET    = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] tile_ui_in,
  output logic [7:0] tile_uio_in,
  output logic       tile_rst_n,
  input  logic [7:0] tile_uo_out,
  input  logic [7:0] tile_uio_out,
  input  logic [7:0] tile_uio_oe,
  output logic       frame_err
);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  heichips25_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .din(spi_sclk),
    .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
  );

  heichips25_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .din(spi_cs_n),
    .sync(cs_sync), .rise(cs_rise), .fall(cs_fall)
  );

  heichips25_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .din(spi_mosi),
    .sync(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_t     state, state_nxt;
  logic [3:0] bit_cnt;
  logic [6:0] shift_in;
  logic [7:0] shift_out;
  logic       cmd_w;
  logic [1:0] cmd_addr;
  logic [7:0] ui_reg, uio_reg;
  logic       rst_n_reg, sticky_abort, loop_bit;
  logic [7:0] new_byte, rd_data, status_rd;
  logic       clr_cnt, shift_en, cmd_latch, commit, abort, miso_shift;
  logic       wr_ui, wr_uio, wr_status;

  assign new_byte = {shift_in, mosi_sync};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which is what would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    clr_cnt    = 1'b0;
    shift_en   = 1'b0;
    cmd_latch  = 1'b0;
    commit     = 1'b0;
    abort      = 1'b0;
    miso_shift = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt = CMD;
          clr_cnt   = 1'b1;
        end
      end
      CMD: begin
        if (cs_rise) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (sclk_rise) begin
          shift_en = 1'b1;
          if (bit_cnt == 4'(BYTE_BITS - 1)) begin
            cmd_latch = 1'b1;
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        // The last rise outranks a coincident cs_n rise: the frame is complete.
        if (sclk_rise && bit_cnt == 4'(FRAME_BITS - 1)) begin
          shift_en  = 1'b1;
          commit    = 1'b1;
          state_nxt = DONE;
        end else if (cs_rise) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          shift_en   = sclk_rise;
          miso_shift = sclk_fall;
        end
      end
      DONE: begin
        if (cs_rise) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    status_rd                 = '0;
    status_rd[STAT_RST_BIT]   = rst_n_reg;
    status_rd[STAT_ABORT_BIT] = sticky_abort;
    status_rd[STAT_LOOP_BIT]  = loop_bit;
    case (new_byte[1:0])
      ADDR_UI:  rd_data = ui_reg;
      ADDR_UIO: rd_data = uio_merge(tile_uio_out, tile_uio_oe, uio_reg);
      ADDR_UO:  rd_data = tile_uo_out;
      default:  rd_data = status_rd;
    endcase
  end

  assign wr_ui     = commit & cmd_w & (cmd_addr == ADDR_UI);
  assign wr_uio    = commit & cmd_w & (cmd_addr == ADDR_UIO);
  assign wr_status = commit & cmd_w & (cmd_addr == ADDR_STATUS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt      <= '0;
      shift_in     <= '0;
      shift_out    <= '0;
      cmd_w        <= 1'b0;
      cmd_addr     <= '0;
      spi_miso     <= 1'b0;
      frame_err    <= 1'b0;
      ui_reg       <= UI_RESET;
      uio_reg      <= UI_RESET;
      rst_n_reg    <= 1'b0;
      sticky_abort <= 1'b0;
    end else begin
      frame_err <= abort;
      if (clr_cnt)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 4'd1;
      if (shift_en) shift_in <= new_byte[6:0];

      // Read data is snapshotted once, at the end of the command byte.
      if (cmd_latch) begin
        cmd_w     <= new_byte[7];
        cmd_addr  <= new_byte[1:0];
        shift_out <= rd_data;
      end else if (miso_shift) begin
        shift_out <= {shift_out[6:0], 1'b0};
      end

      if (miso_shift)              spi_miso <= shift_out[7];
      else if (state_nxt != DATA)  spi_miso <= 1'b0;

      if (wr_ui)  ui_reg  <= new_byte;
      if (wr_uio) uio_reg <= new_byte;
      if (wr_status) begin
        rst_n_reg <= new_byte[STAT_RST_BIT];
        if (new_byte[STAT_ABORT_BIT]) sticky_abort <= 1'b0;
      end
      if (abort) sticky_abort <= 1'b1;
    end
  end

  assign spi_miso_oe = ~cs_sync;
  assign tile_uio_in = uio_reg;
  assign tile_rst_n  = rst_n_reg;

`ifdef HEICHIPS25_SPI_BRIDGE_LOOPBACK_EN
  logic       loop_reg;
  logic [7:0] uo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loop_reg <= 1'b0;
      uo_q     <= '0;
    end else begin
      uo_q <= tile_uo_out;
      if (wr_status) loop_reg <= new_byte[STAT_LOOP_BIT];
    end
  end

  assign loop_bit   = loop_reg;
  assign tile_ui_in = loop_reg ? uo_q : ui_reg;
`else
  assign loop_bit   = 1'b0;
  assign tile_ui_in = ui_reg;
`endif

endmodule

// File: tb/tb_heichips25_spi_io_bridge.sv
// Directed self-checking bench for heichips25_spi_io_bridge (SYNC_STAGES = 2).
module tb_heichips25_spi_io_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_sclk, spi_cs_n, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] tile_ui_in, tile_uio_in;
  logic       tile_rst_n;
  logic [7:0] tile_uo_out, tile_uio_out, tile_uio_oe;
  logic       frame_err;

  int n_checks = 0;
  int n_errors = 0;

  localparam int HALF = 6;  // SCLK half period in clks, >= SYNC_STAGES+2

  heichips25_spi_io_bridge #(.SYNC_STAGES(2), .UI_RESET(8'h00)) dut (
    .clk(clk), .rst(rst),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .tile_ui_in(tile_ui_in), .tile_uio_in(tile_uio_in), .tile_rst_n(tile_rst_n),
    .tile_uo_out(tile_uo_out), .tile_uio_out(tile_uio_out), .tile_uio_oe(tile_uio_oe),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic spi_start();
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    repeat (HALF) @(negedge clk);
    m = spi_miso;
    spi_sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_sclk = 1'b0;
  endtask

  task automatic spi_stop();
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [15:0] tx, input int nbits, output logic [7:0] rx);
    logic m;
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_bit(tx[15-i], m);
      if (i >= 8) rx[15-i] = m;
    end
  endtask

  task automatic spi_xfer(input logic [15:0] tx, output logic [7:0] rx);
    spi_start();
    spi_bits(tx, 16, rx);
    spi_stop();
  endtask

  initial begin
    logic [7:0]  rx;
    logic [15:0] tx;
    rst = 1'b1;
    spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    tile_uo_out = 8'h00; tile_uio_out = 8'h00; tile_uio_oe = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    check("rst_ui_in", tile_ui_in, 8'h00);
    check("rst_uio_in", tile_uio_in, 8'h00);
    check("rst_tile_rst_n", tile_rst_n, 1'b0);
    check("rst_miso", spi_miso, 1'b0);
    check("rst_miso_oe", spi_miso_oe, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);

    // Write UI with commit timing: pin rise -> detect after 3 clks -> register after 4.
    tx = 16'h80A5;
    spi_start();
    spi_bits(tx, 15, rx);
    spi_mosi = tx[0];
    repeat (HALF) @(negedge clk);
    spi_sclk = 1'b1;
    repeat (3) @(negedge clk);
    check("ui_before_commit", tile_ui_in, 8'h00);
    @(negedge clk);
    check("ui_commit", tile_ui_in, 8'hA5);
    repeat (HALF - 4) @(negedge clk);
    spi_sclk = 1'b0;
    spi_stop();

    spi_xfer(16'h8301, rx);
    check("status_release_rst", tile_rst_n, 1'b1);

    tile_uo_out = 8'h3C;
    spi_xfer(16'h0200, rx);
    check("read_uo", rx, 8'h3C);

    spi_xfer(16'h81F0, rx);
    check("write_uio", tile_uio_in, 8'hF0);
    tile_uio_oe = 8'h0F; tile_uio_out = 8'h05;
    spi_xfer(16'h0100, rx);
    check("read_uio_merge", rx, 8'hF5);

    spi_xfer(16'h0000, rx);
    check("read_ui", rx, 8'hA5);

    spi_xfer(16'h82FF, rx);
    check("uo_write_dropped_ui", tile_ui_in, 8'hA5);
    check("uo_write_dropped_uio", tile_uio_in, 8'hF0);

    // Abort after 11 bits.
    spi_start();
    check("miso_oe_active", spi_miso_oe, 1'b1);
    spi_bits(16'h80FF, 11, rx);
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_err_early", frame_err, 1'b0);
    @(negedge clk);
    check("abort_err_pulse", frame_err, 1'b1);
    @(negedge clk);
    check("abort_err_end", frame_err, 1'b0);
    repeat (6) @(negedge clk);
    check("abort_ui_unchanged", tile_ui_in, 8'hA5);
    spi_xfer(16'h0300, rx);
    check("status_after_abort", rx, 8'h03);
    spi_xfer(16'h8302, rx);
    spi_xfer(16'h0300, rx);
    check("status_cleared", rx, 8'h00);
    check("tile_rst_n_reasserted", tile_rst_n, 1'b0);

    // Mid-frame reset after 12 bits.
    spi_start();
    spi_bits(16'h8011, 12, rx);
    repeat (2) @(negedge clk);
    rst = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0;
    #1;
    check("midrst_ui_in", tile_ui_in, 8'h00);
    check("midrst_uio_in", tile_uio_in, 8'h00);
    check("midrst_tile_rst_n", tile_rst_n, 1'b0);
    check("midrst_miso_oe", spi_miso_oe, 1'b0);
    check("midrst_miso", spi_miso, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    spi_xfer(16'h805A, rx);
    check("post_rst_write", tile_ui_in, 8'h5A);

`ifdef HEICHIPS25_SPI_BRIDGE_LOOPBACK_EN
    spi_xfer(16'h8304, rx);
    tile_uo_out = 8'h77;
    @(negedge clk);
    check("loopback_ui", tile_ui_in, 8'h77);
    spi_xfer(16'h0300, rx);
    check("loopback_status", rx, 8'h04);
`else
    spi_xfer(16'h8304, rx);
    spi_xfer(16'h0300, rx);
    check("no_loopback_status", rx, 8'h00);
    check("no_loopback_ui", tile_ui_in, 8'h5A);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/heichips25_spi_io_bridge.md
Name: heichips25_spi_io_bridge

Overview:
- Bring-up stage directly upstream of a heichips25 user tile.
- Converts an external SPI-slave (mode 0) link into the tile's parallel pins: drives tile ui_in, uio_in and tile reset; samples uo_out, uio_out and uio_oe for readback.
- All SPI pins are oversampled in the clk domain, so no SCLK-clocked logic exists.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for spi_sclk/spi_cs_n/spi_mosi; legal values 2..3.
- UI_RESET, 8'h00, reset value of tile_ui_in and tile_uio_in.

Ports:
- clk  in  1  system clock, also the tile clock.
- rst  in  1  asynchronous, active-high reset.
- spi_sclk  in  1  SPI clock; requires f_sclk <= f_clk/(2*(SYNC_STAGES+2)).
- spi_cs_n  in  1  SPI chip select, active low.
- spi_mosi  in  1  SPI data in.
- spi_miso  out  1  SPI data out.
- spi_miso_oe  out  1  MISO pad enable; equals synchronised ~cs_n.
- tile_ui_in  out  8  to tile ui_in.
- tile_uio_in  out  8  to tile uio_in.
- tile_rst_n  out  1  to tile rst_n.
- tile_uo_out  in  8  from tile uo_out.
- tile_uio_out  in  8  from tile uio_out.
- tile_uio_oe  in  8  from tile uio_oe.
- frame_err  out  1  one-clk pulse on an aborted frame.

Behaviour:
- Reset values:
  - tile_ui_in = tile_uio_in = UI_RESET.
  - tile_rst_n = 0: tile is held in reset until software releases it.
  - spi_miso = 0, spi_miso_oe = 0, frame_err = 0, sticky_abort = 0.
  - FSM in IDLE, bit counter = 0.
- Edge detection:
  - Rising and falling SCLK edges are detected on the last two synchroniser stages.
  - A detected edge lags the pin by SYNC_STAGES+1 clks.
- Frame format: 16 bits, MSB first.
  - Byte0 = command: bit7 is W (1 = write, 0 = read); bits[1:0] are ADDR; bits[6:2] are ignored.
  - Byte1 = write data. For a read, byte1 from MOSI is ignored.
- Register map:
  - ADDR 0 = UI (read and write, drives tile_ui_in).
  - ADDR 1 = UIO (write sets tile_uio_in; read returns (tile_uio_out & tile_uio_oe) | (tile_uio_in & ~tile_uio_oe)).
  - ADDR 2 = UO (read-only, tile_uo_out; writes are dropped).
  - ADDR 3 = STATUS: bit0 is tile_rst_n (read/write); bit1 is sticky_abort (read; writing 1 clears it); bit2 is reserved (see optional feature); other bits read 0.
- FSM:
  - IDLE -> CMD on synchronised cs_n falling. Bit counter clears.
  - CMD: each detected SCLK rise shifts in MOSI. On the 8th rise, latch the command, capture the read data for ADDR into shift_out, and go to DATA.
  - DATA: on each detected SCLK fall, spi_miso takes the next shift_out bit, MSB first. The first fall after the 8th rise presents bit7.
  - DATA: on the 16th rise, a write commits. The target register updates on the following clk edge, i.e. 1 clk after the detected edge. Then go to DONE.
  - DONE: extra SCLK edges are ignored and spi_miso holds 0. cs_n rise -> IDLE.
  - In CMD, spi_miso = 0.
- Abort:
  - cs_n rising in CMD or DATA before the 16th rise -> IDLE, with no register change.
  - The abort pulses frame_err for 1 clk and sets sticky_abort.
- Simultaneous events:
  - cs_n rise and the 16th SCLK rise detected in the same clk: the write commits and no abort is flagged.
  - A STATUS write of bit1 = 1 in the same clk as a new abort: the set wins.
- Read snapshot: read data is sampled once, at the 8th rise. Tile changes during byte1 are not reflected.
- rst mid-frame: all state returns to reset values immediately (asynchronous). The next frame needs a fresh cs_n falling edge seen from IDLE.

Optional Feature:
- Macro: HEICHIPS25_SPI_BRIDGE_LOOPBACK_EN.
- Defined:
  - STATUS bit2 = loopback, read/write, reset 0.
  - When bit2 = 1, tile_ui_in = registered tile_uo_out (1 clk delay) and the UI register is retained but not driven out.
  - When bit2 = 0, tile_ui_in = UI register.
- Undefined: bit2 reads 0, writes to it are ignored, and no loopback logic is present.

Decomposition:
- Package heichips25_spi_bridge_pkg holds:
  - the FSM state enum (IDLE, CMD, DATA, DONE);
  - address constants ADDR_UI = 2'd0, ADDR_UIO = 2'd1, ADDR_UO = 2'd2, ADDR_STATUS = 2'd3;
  - STATUS bit indices and the frame length constant (16).
- One sub-module: heichips25_sync_edge. It is the SYNC_STAGES synchroniser plus rise/fall detect, instanced 3 times (edge outputs unused for mosi).

Test Plan:
- Reset release: every output holds its reset value, including tile_rst_n = 0 and tile_ui_in = 8'h00.
- Write UI: frame 16'h80A5 -> tile_ui_in = 8'hA5 exactly 1 clk after the detected 16th rise.
- Write STATUS 16'h8301 -> tile_rst_n = 1. Then read UO (16'h0200) with tile_uo_out = 8'h3C -> MISO shifts 0011_1100 during byte1.
- UIO merge read: tile_uio_in = 8'hF0, tile_uio_oe = 8'h0F, tile_uio_out = 8'h05, read 16'h0100 -> MISO returns 8'hF5.
- Abort: raise cs_n after 11 bits of 16'h80FF -> tile_ui_in unchanged, frame_err pulses 1 clk, STATUS read = 8'h03. Then write 16'h8302 clears bit1.
- Mid-frame rst after 12 bits -> all outputs return to reset. The next full frame 16'h805A is accepted, giving tile_ui_in = 8'h5A. With the loopback macro defined and bit2 set, tile_ui_in follows tile_uo_out one clk later.
